// File: rtl/sram_controller.sv
// Bridges the 32-bit MEM-stage data port to a 16-bit asynchronous SRAM.
// Each load or store becomes two half-word accesses, low half first, while ready holds the pipeline.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int               CNT_W = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [16:0]      word_addr;
    logic [16:0]      word_next;
    logic [31:0]      wdata_q;
    logic             is_write;
    logic [17:0]      addr_hold;
    logic             active;
    logic             phase_last;
    logic             request;
    logic             dq_drive;
    logic [15:0]      dq_out;

    assign request    = wr_en | rd_en;
    assign active     = (state == LOW) || (state == HIGH);
    assign phase_last = (cnt == LAST);
    // Wrap-around subtraction; bits below 2 and above 18 of the offset are simply dropped.
    assign word_next  = 17'((address - BASE_ADDR) >> 2);

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (request) begin
                    state_next = LOW;
                    cnt_next   = '0;
                end
            end
            LOW: begin
                if (phase_last) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_addr <= '0;
            wdata_q   <= '0;
            is_write  <= 1'b0;
            addr_hold <= '0;
            read_data <= '0;
        end else begin
            if (state == IDLE && request) begin
                word_addr <= word_next;
                wdata_q   <= write_data;
                is_write  <= wr_en;
            end
            if (active) begin
                addr_hold <= SRAM_ADDR;
            end
            // The SRAM has had the whole phase to settle by its final cycle.
            if (active && !is_write && phase_last) begin
                if (state == LOW) begin
                    read_data[15:0] <= SRAM_DQ;
                end else begin
                    read_data[31:16] <= SRAM_DQ;
                end
            end
        end
    end

    // Strobes decode straight from state so an asynchronous reset releases them instantly.
    assign SRAM_ADDR = active ? {word_addr, state == HIGH} : addr_hold;
    assign SRAM_CE_N = ~active;
    assign SRAM_UB_N = ~active;
    assign SRAM_LB_N = ~active;
    assign SRAM_WE_N = ~(active & is_write & ~phase_last);
    assign SRAM_OE_N = ~(active & ~is_write);

    assign dq_drive = active & is_write;
    assign dq_out   = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ  = dq_drive ? dq_out : 16'bz;

    assign ready = ((state == IDLE) && !request) || (state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed table, back-to-back and reset sequences, then random traffic
// compared against a word-level memory model and a simple SRAM behavioural model.
module tb_sram_controller;

    localparam int          W    = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        wr_en      = 1'b0;
    logic        rd_en      = 1'b0;
    logic [31:0] address    = '0;
    logic [31:0] write_data = '0;
    wire  [31:0] read_data;
    wire         ready;
    wire  [15:0] sram_dq;
    wire  [17:0] sram_addr;
    wire         sram_we_n;
    wire         sram_oe_n;
    wire         sram_ce_n;
    wire         sram_ub_n;
    wire         sram_lb_n;

    int checks = 0;
    int errors = 0;

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_OE_N  (sram_oe_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n)
    );

    always #5 clk = ~clk;

    // Behavioural asynchronous SRAM: drives the bus while output-enabled, stores on a clocked write strobe.
    logic [15:0] sram_mem [0:262143];
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'bz;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_dq;
    end

    // Reference model: 32-bit words keyed by word index, plus the last loaded value.
    logic [31:0] ref_mem [int];
    logic [31:0] ref_rd;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) & 32'h1FFFF);
    endfunction

    // Entered just after a falling edge with the DUT idle; returns one cycle after DONE.
    task automatic do_access(input logic wr, input logic rd, input logic [31:0] a,
                             input logic [31:0] wd, input bit hold);
        int          c;
        int          wi;
        bit          done_seen;
        logic [31:0] old_rd;
        logic [31:0] exp_word;
        wr_en      = wr;
        rd_en      = rd;
        address    = a;
        write_data = wd;
        wi         = word_of(a);
        old_rd     = ref_rd;
        exp_word   = ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
        #1;
        check("ready_cycle0", ready, 0);
        c         = 0;
        done_seen = 0;
        while (!done_seen && c <= 4 * W + 4) begin
            @(negedge clk);
            #1;
            c++;
            if (ready) begin
                done_seen = 1;
            end else if (c <= 2 * W) begin
                int ph;
                int pos;
                ph  = (c - 1) / W;
                pos = (c - 1) % W;
                check("ce_n_active", sram_ce_n, 0);
                check("ub_lb_n_active", {sram_ub_n, sram_lb_n}, 0);
                check("sram_addr", sram_addr, 32'(wi * 2 + ph));
                check("we_n", sram_we_n, (wr && pos < W - 1) ? 32'd0 : 32'd1);
                check("oe_n", sram_oe_n, wr ? 32'd1 : 32'd0);
                if (wr) check("dq_write", sram_dq, ph == 0 ? wd[15:0] : wd[31:16]);
                if (!wr && c == W) check("read_data_before_sample", read_data, old_rd);
            end
        end
        check("ready_latency", c, 2 * W + 1);
        if (wr) ref_mem[wi] = wd;
        else    ref_rd = exp_word;
        check("done_read_data", read_data, ref_rd);
        check("done_strobes", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b111);
        if (wr) begin
            check("sram_word_low", sram_mem[wi * 2], wd[15:0]);
            check("sram_word_high", sram_mem[wi * 2 + 1], wd[31:16]);
        end
        if (!hold) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
        @(negedge clk);
        #1;
        if (!hold) check("ready_idle", ready, 1);
        check("sram_addr_hold", sram_addr, 32'(wi * 2 + 1));
        check("ce_n_idle", sram_ce_n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
        ref_rd = 32'h0;

        vecs[0] = '{1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{1'b0, 1'b1, 32'd1032, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 32'd1024, 32'hA5A5A5A5, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, 32'h12345678};
        vecs[5] = '{1'b0, 1'b1, 32'd1020, 32'hA5A5A5A5, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 1'b1, 32'd1035, 32'hA5A5A5A5, 32'hDEADBEEF};

        #3;
        check("reset_ready", ready, 1);
        check("reset_read_data", read_data, 0);
        check("reset_strobes", {sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}, 5'b11111);
        check("reset_sram_addr", sram_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        for (int i = 0; i < 7; i++) begin
            do_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, 1'b0);
            check("table_read_data", read_data, vecs[i].exp_rd);
        end

        // Request held through DONE starts a second access; the old word survives until LOW samples.
        do_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b1);
        check("b2b_first", read_data, 32'hDEADBEEF);
        do_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
        check("b2b_second", read_data, 32'h12345678);

        // Asynchronous reset in the high phase of a write, away from any clock edge.
        wr_en      = 1'b1;
        address    = 32'd1424;
        write_data = 32'h0BADCAFE;
        repeat (W + 1) @(negedge clk);
        #1;
        check("mid_write_we_n", sram_we_n, 0);
        #2;
        rst = 1'b0;
        #1;
        check("abort_strobes", {sram_we_n, sram_oe_n, sram_ce_n}, 3'b111);
        check("abort_sram_addr", sram_addr, 0);
        wr_en = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_read_data", read_data, 0);
        ref_rd = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_ready", ready, 1);

        for (int i = 0; i < 40; i++) begin
            logic        wr;
            logic        rd;
            logic [31:0] a;
            bit          hold;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 3) == 0)
                a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
            else
                a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            hold = (i < 39) && ($urandom_range(0, 3) == 0);
            do_access(wr, rd, a, $urandom, hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits directly downstream of the MEM stage, between the pipeline's 32-bit data-memory request and the external 16-bit SRAM pins.
- Converts each 32-bit load or store into two sequential half-word SRAM accesses: low half first, then high half.
- Drives `ready` low for the whole access so the pipeline freezes; `ready` returns high for exactly one cycle when the access completes.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 2: cycles spent on each half-word phase; must be >= 2.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  store request, held by the pipeline until ready.
- rd_en  in  1  load request, held by the pipeline until ready.
- address  in  32  byte address from the ALU result.
- write_data  in  32  store value (Val_Rm).
- read_data  out  32  load result.
- ready  out  1  high = no access pending, or access completing this cycle.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM half-word address.
- SRAM_WE_N  out  1  write strobe, active-low.
- SRAM_OE_N  out  1  output enable, active-low.
- SRAM_CE_N  out  1  chip enable, active-low.
- SRAM_UB_N  out  1  upper-byte enable, active-low.
- SRAM_LB_N  out  1  lower-byte enable, active-low.

Behaviour:
- States: IDLE, LOW, HIGH, DONE. A phase counter runs 0..WAIT_CYCLES-1 inside LOW and HIGH.
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, read_data=0, latched address/data/op cleared.
  - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_CE_N=1, SRAM_UB_N=1, SRAM_LB_N=1, SRAM_ADDR=0, SRAM_DQ=Z.
  - Reset mid-access aborts immediately. WE_N rises the same instant; no completion of the partial write is guaranteed.
- IDLE:
  - If wr_en|rd_en, latch address, write_data and op, then go to LOW.
  - wr_en wins when both are asserted.
- LOW:
  - Stay WAIT_CYCLES cycles, then go to HIGH with counter reset.
- HIGH:
  - Stay WAIT_CYCLES cycles, then go to DONE.
- DONE:
  - Always returns to IDLE after one cycle. The request signals are ignored in DONE.
  - A still-asserted request in the following IDLE cycle is a new access.
- ready:
  - Combinational: (IDLE & ~wr_en & ~rd_en) | DONE.
  - Request seen in IDLE at cycle 0 → ready low for cycles 0..2*WAIT_CYCLES, high at cycle 2*WAIT_CYCLES+1. Default: 6-cycle access.
- Address mapping:
  - offset = address - BASE_ADDR, 32-bit wrap-around subtraction.
  - LOW drives SRAM_ADDR = {offset[18:2],1'b0}; HIGH drives {offset[18:2],1'b1}.
  - offset[1:0] is ignored (word-aligned only). Addresses below BASE_ADDR wrap modulo 2^19 bytes; no error is flagged.
- Enables:
  - SRAM_CE_N, SRAM_UB_N and SRAM_LB_N are 0 in LOW/HIGH and 1 otherwise.
  - SRAM_ADDR holds its last value outside LOW/HIGH.
- Write:
  - SRAM_DQ = write_data[15:0] in LOW and write_data[31:16] in HIGH. Otherwise Z.
  - SRAM_WE_N=0 for counter 0..WAIT_CYCLES-2 of each phase and 1 on the last cycle, so address changes only with WE_N high.
  - SRAM_OE_N=1 throughout.
- Read:
  - SRAM_DQ=Z; SRAM_OE_N=0 in LOW/HIGH.
  - On the last cycle of LOW, sample DQ into read_data[15:0]; on the last cycle of HIGH, into read_data[31:16].
  - read_data is valid in DONE and holds until the next read overwrites it. Writes never modify read_data.
- SRAM_DQ is never driven in IDLE or DONE, and never during read phases.

Test Plan:
- Store, address=1032, write_data=0xDEADBEEF:
  - SRAM_ADDR=4 with DQ=0xBEEF and WE_N=0 for 1 cycle, then SRAM_ADDR=5 with DQ=0xDEAD.
  - ready low 5 cycles, high in cycle 5; SRAM model words 4/5 = 0xBEEF/0xDEAD.
- Load, address=1032, after the store above: read_data=0xDEADBEEF in DONE; OE_N=0 for 4 cycles; DQ never driven by the DUT.
- Back-to-back: rd_en held through DONE and into the next cycle → second access starts, ready low again for 5 cycles, and read_data stays 0xDEADBEEF until the second read's LOW phase samples.
- wr_en=rd_en=1 at address=1024, write_data=0x12345678 → write performed; SRAM words 0/1 = 0x5678/0x1234; read_data unchanged.
- Reset asserted in HIGH of a write: WE_N, CE_N and OE_N go to 1 and DQ to Z without waiting for clk. After release: IDLE, ready=1, read_data=0.
- address=1020 (below BASE_ADDR) → offset=0xFFFFFFFC, SRAM_ADDR=0x3FFFE then 0x3FFFF.
